// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file of the 5-stage MIPS pipeline.
// Commits MEM/WB writes, serves two bypassed ID read ports, and executes halt/display syscalls.
module wb_regfile #(
    parameter int DATA_W    = 32,
    parameter int HALT_CODE = 10,
    parameter int V0_IDX    = 2,
    parameter int A0_IDX    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_syscall,
    input  logic              wb_we,
    input  logic [4:0]        wb_rw,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              halt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic [31:0]       cycle_cnt
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;

    localparam logic [4:0]        V0_ADDR   = 5'(V0_IDX);
    localparam logic [4:0]        A0_ADDR   = 5'(A0_IDX);
    localparam logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_CODE);

    logic              state;
    logic [DATA_W-1:0] regs [32];
    logic [4:0]        port_addr [4];
    logic [DATA_W-1:0] port_data [4];
    logic [DATA_W-1:0] v0_eff;
    logic [DATA_W-1:0] a0_eff;
    logic              run_we;

    assign run_we = (state == STATE_RUN) && wb_we;

    assign port_addr[0] = ra1;
    assign port_addr[1] = ra2;
    assign port_addr[2] = V0_ADDR;
    assign port_addr[3] = A0_ADDR;

    // The syscall code/argument share the bypassed read path with the ID ports,
    // so a syscall sees a write arriving in the same bundle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            port_data[i] = regs[port_addr[i]];
            if (port_addr[i] == 5'd0) begin
                port_data[i] = '0;
            end else if (run_we && (wb_rw == port_addr[i])) begin
                port_data[i] = wb_data;
            end
        end
    end

    assign rd1    = port_data[0];
    assign rd2    = port_data[1];
    assign v0_eff = port_data[2];
    assign a0_eff = port_data[3];
    assign halt   = (state == STATE_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            state      <= STATE_RUN;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cycle_cnt  <= '0;
        end else begin
            disp_valid <= 1'b0;
            if (state == STATE_RUN) begin
                if (run_we && (wb_rw != 5'd0)) begin
                    regs[wb_rw] <= wb_data;
                end
                // Counter saturates rather than wrapping so a long run never reads as short.
                if (cycle_cnt != 32'hFFFF_FFFF) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
                if (wb_syscall) begin
                    if (v0_eff == HALT_WORD) begin
                        state <= STATE_HALT;
                    end else begin
                        disp_data  <= a0_eff;
                        disp_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised scoreboard bench for wb_regfile against a high-level machine model.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares them.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_syscall = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rw = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        halt;
    logic        disp_valid;
    logic [31:0] disp_data;
    logic [31:0] cycle_cnt;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          chk;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        halt;
        logic        dv;
        logic [31:0] dd;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference machine state, as observable after the most recent clock edge.
    logic [31:0] m_regs [32];
    bit          m_halted;
    bit          m_dv;
    logic [31:0] m_dd;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_syscall (wb_syscall),
        .wb_we      (wb_we),
        .wb_rw      (wb_rw),
        .wb_data    (wb_data),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .halt       (halt),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .cycle_cnt  (cycle_cnt)
    );

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!m_halted && wb_we && wb_rw == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One bus cycle: drive the bundle, record what the DUT must show this cycle,
    // then advance the model across the coming edge.
    task automatic applyStimulus(input bit chk, input bit r, input bit sys, input bit we,
                                 input logic [4:0] rw, input logic [31:0] data,
                                 input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic [31:0] v0;
        logic [31:0] a0;
        @(posedge clk);
        #1;
        rst = r; wb_syscall = sys; wb_we = we; wb_rw = rw; wb_data = data; ra1 = a1; ra2 = a2;
        e.chk  = chk;
        e.rd1  = model_read(a1);
        e.rd2  = model_read(a2);
        e.halt = m_halted;
        e.dv   = m_dv;
        e.dd   = m_dd;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        v0 = model_read(5'd2);
        a0 = model_read(5'd4);
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_halted = 0; m_dv = 0; m_dd = 32'd0; m_cnt = 32'd0;
        end else if (m_halted) begin
            m_dv = 0;
        end else begin
            m_dv = 0;
            if (we && rw != 5'd0) m_regs[rw] = data;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (sys) begin
                if (v0 == 32'd10) m_halted = 1;
                else begin m_dv = 1; m_dd = a0; end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checkOutput("rd1", rd1, e.rd1);
                checkOutput("rd2", rd2, e.rd2);
                checkOutput("halt", {31'd0, halt}, {31'd0, e.halt});
                checkOutput("disp_valid", {31'd0, disp_valid}, {31'd0, e.dv});
                if (e.dv) checkOutput("disp_data", disp_data, e.dd);
                checkOutput("cycle_cnt", cycle_cnt, e.cnt);
            end
        end
    end

    initial begin
        bit          r;
        bit          sys;
        bit          we;
        logic [4:0]  rw;
        logic [31:0] data;
        int          wait_cycles;

        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_halted = 0; m_dv = 0; m_dd = 32'd0; m_cnt = 32'd0;

        // Reset; DUT state before this first edge is unknown, so it is not checked.
        applyStimulus(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        applyStimulus(1, 0, 0, 1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd5, 5'd6);
        applyStimulus(1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        applyStimulus(1, 0, 0, 1, 5'd7, 32'h0000_00A5, 5'd5, 5'd7);
        applyStimulus(1, 0, 0, 1, 5'd2, 32'd1, 5'd7, 5'd2);
        applyStimulus(1, 0, 0, 1, 5'd4, 32'd42, 5'd2, 5'd4);
        applyStimulus(1, 0, 1, 0, 5'd0, 32'd0, 5'd4, 5'd0);
        applyStimulus(1, 0, 1, 1, 5'd4, 32'd99, 5'd4, 5'd2);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd4, 5'd0);
        applyStimulus(1, 0, 0, 1, 5'd2, 32'd10, 5'd2, 5'd0);
        applyStimulus(1, 0, 1, 0, 5'd0, 32'd0, 5'd2, 5'd0);
        applyStimulus(1, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd0);
        applyStimulus(1, 0, 1, 1, 5'd2, 32'd1, 5'd3, 5'd2);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd3, 5'd5);
        applyStimulus(1, 1, 0, 0, 5'd0, 32'd0, 5'd5, 5'd7);
        applyStimulus(1, 0, 0, 1, 5'd9, 32'h0BAD_F00D, 5'd5, 5'd7);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd9, 5'd2);

        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 3);
            sys = ($urandom_range(0, 99) < 15);
            we  = ($urandom_range(0, 99) < 60);
            rw  = (($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
            case ($urandom_range(0, 3))
                0:       data = 32'd10;
                1:       data = 32'($urandom_range(0, 15));
                default: data = $urandom;
            endcase
            if (m_halted && $urandom_range(0, 9) == 0) r = 1;
            applyStimulus(1, r, sys, we, rw, data,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 5'd2, 5'd4);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        #1;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
